alu_issue: RTL and testbench

Sequential front end that accepts one R-type arithmetic/logic request at a time on a valid/ready handshake. It decodes the 6-bit MIPS funct, drives the existing 3-op-bit combinational ALU through registered operand/op outputs, and collects the ALU's Result/Overflow. It returns the final result, zero flag and exception flags on a second valid/ready handshake. It sits between the decode stage of the multi-cycle CPU and the ALU. It also synthesizes XOR (two ALU passes) and SLTU (operand MSB flip), which the ALU does not support directly.

---
 rtl/alu_issue_if.sv | 36 +++
 rtl/alu_issue.sv | 190 +++++++++++++++++++
 tb/tb_alu_issue.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_if.sv
// Request, ALU-drive and response signal bundle for alu_issue.
// The slave modport is the issue block's view; master is the surrounding datapath/bench.
interface alu_issue_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic [5:0]            req_funct;
  logic [DATA_WIDTH-1:0] req_a;
  logic [DATA_WIDTH-1:0] req_b;

  logic [DATA_WIDTH-1:0] alu_A;
  logic [DATA_WIDTH-1:0] alu_B;
  logic [2:0]            alu_op;
  logic [DATA_WIDTH-1:0] alu_result;
  logic                  alu_overflow;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_result;
  logic                  rsp_zero;
  logic                  rsp_ovf;
  logic                  rsp_illegal;

  modport slave (
    input  req_valid, req_funct, req_a, req_b, alu_result, alu_overflow, rsp_ready,
    output req_ready, alu_A, alu_B, alu_op, rsp_valid, rsp_result, rsp_zero, rsp_ovf,
           rsp_illegal
  );

  modport master (
    output req_valid, req_funct, req_a, req_b, alu_result, alu_overflow, rsp_ready,
    input  req_ready, alu_A, alu_B, alu_op, rsp_valid, rsp_result, rsp_zero, rsp_ovf,
           rsp_illegal
  );
endinterface

// File: rtl/alu_issue.sv
// Sequential R-type issue front end: decodes funct, drives the 3-bit-op ALU through registers,
// and synthesizes XOR (AND pass then OR pass) and SLTU (MSB-flipped signed compare).
module alu_issue #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input logic        clk,
  input logic        rst,
  alu_issue_if.slave bus
);

  localparam logic [5:0] FnAdd  = 6'h20;
  localparam logic [5:0] FnAddu = 6'h21;
  localparam logic [5:0] FnSub  = 6'h22;
  localparam logic [5:0] FnSubu = 6'h23;
  localparam logic [5:0] FnAnd  = 6'h24;
  localparam logic [5:0] FnOr   = 6'h25;
  localparam logic [5:0] FnXor  = 6'h26;
  localparam logic [5:0] FnSlt  = 6'h2A;
  localparam logic [5:0] FnSltu = 6'h2B;

  localparam logic [2:0] OpAnd = 3'b000;
  localparam logic [2:0] OpOr  = 3'b001;
  localparam logic [2:0] OpAdd = 3'b010;
  localparam logic [2:0] OpSub = 3'b110;
  localparam logic [2:0] OpSlt = 3'b111;

  localparam logic [DATA_WIDTH-1:0] MsbMask = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    StIdle,
    StEx1,
    StEx2,
    StResp
  } state_e;

  state_e                r_state;
  logic [5:0]            r_funct;
  logic [DATA_WIDTH-1:0] r_temp;
  logic [DATA_WIDTH-1:0] r_alu_a;
  logic [DATA_WIDTH-1:0] r_alu_b;
  logic [2:0]            r_alu_op;
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_result;
  logic                  r_rsp_zero;
  logic                  r_rsp_ovf;
  logic                  r_rsp_illegal;

  state_e                w_state_nxt;
  logic [5:0]            w_funct_nxt;
  logic [DATA_WIDTH-1:0] w_temp_nxt;
  logic [DATA_WIDTH-1:0] w_alu_a_nxt;
  logic [DATA_WIDTH-1:0] w_alu_b_nxt;
  logic [2:0]            w_alu_op_nxt;
  logic                  w_rsp_valid_nxt;
  logic [DATA_WIDTH-1:0] w_rsp_result_nxt;
  logic                  w_rsp_zero_nxt;
  logic                  w_rsp_ovf_nxt;
  logic                  w_rsp_illegal_nxt;

  logic [2:0]            w_dec_op;
  logic                  w_dec_legal;
  logic [DATA_WIDTH-1:0] w_dec_mask;
  logic                  w_signed_op;
  logic [DATA_WIDTH-1:0] w_xor_result;

  // XOR issues AND first; its result is kept in r_temp for the OR pass.
  always_comb begin
    w_dec_op    = OpAnd;
    w_dec_legal = 1'b1;
    w_dec_mask  = '0;
    case (bus.req_funct)
      FnAnd, FnXor:   w_dec_op = OpAnd;
      FnOr:           w_dec_op = OpOr;
      FnAdd, FnAddu:  w_dec_op = OpAdd;
      FnSub, FnSubu:  w_dec_op = OpSub;
      FnSlt:          w_dec_op = OpSlt;
      FnSltu: begin
        w_dec_op   = OpSlt;
        w_dec_mask = MsbMask;
      end
      default:        w_dec_legal = 1'b0;
    endcase
  end

  assign w_signed_op  = (r_funct == FnAdd) || (r_funct == FnSub);
  assign w_xor_result = bus.alu_result & ~r_temp;

  always_comb begin
    w_state_nxt       = r_state;
    w_funct_nxt       = r_funct;
    w_temp_nxt        = r_temp;
    w_alu_a_nxt       = r_alu_a;
    w_alu_b_nxt       = r_alu_b;
    w_alu_op_nxt      = r_alu_op;
    w_rsp_valid_nxt   = r_rsp_valid;
    w_rsp_result_nxt  = r_rsp_result;
    w_rsp_zero_nxt    = r_rsp_zero;
    w_rsp_ovf_nxt     = r_rsp_ovf;
    w_rsp_illegal_nxt = r_rsp_illegal;

    case (r_state)
      StIdle: begin
        if (bus.req_valid) begin
          w_funct_nxt  = bus.req_funct;
          w_alu_a_nxt  = bus.req_a ^ w_dec_mask;
          w_alu_b_nxt  = bus.req_b ^ w_dec_mask;
          w_alu_op_nxt = w_dec_op;
          if (w_dec_legal) begin
            w_state_nxt = StEx1;
          end else begin
            w_state_nxt       = StResp;
            w_rsp_valid_nxt   = 1'b1;
            w_rsp_result_nxt  = '0;
            w_rsp_zero_nxt    = 1'b1;
            w_rsp_ovf_nxt     = 1'b0;
            w_rsp_illegal_nxt = 1'b1;
          end
        end
      end
      StEx1: begin
        if (r_funct == FnXor) begin
          w_temp_nxt   = bus.alu_result;
          w_alu_op_nxt = OpOr;
          w_state_nxt  = StEx2;
        end else begin
          w_state_nxt       = StResp;
          w_rsp_valid_nxt   = 1'b1;
          w_rsp_result_nxt  = bus.alu_result;
          w_rsp_zero_nxt    = (bus.alu_result == '0);
          w_rsp_ovf_nxt     = w_signed_op & bus.alu_overflow;
          w_rsp_illegal_nxt = 1'b0;
        end
      end
      StEx2: begin
        w_state_nxt       = StResp;
        w_rsp_valid_nxt   = 1'b1;
        w_rsp_result_nxt  = w_xor_result;
        w_rsp_zero_nxt    = (w_xor_result == '0);
        w_rsp_ovf_nxt     = 1'b0;
        w_rsp_illegal_nxt = 1'b0;
      end
      StResp: begin
        if (bus.rsp_ready) begin
          w_state_nxt     = StIdle;
          w_rsp_valid_nxt = 1'b0;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= StIdle;
      r_funct       <= '0;
      r_temp        <= '0;
      r_alu_a       <= '0;
      r_alu_b       <= '0;
      r_alu_op      <= OpAnd;
      r_rsp_valid   <= 1'b0;
      r_rsp_result  <= '0;
      r_rsp_zero    <= 1'b0;
      r_rsp_ovf     <= 1'b0;
      r_rsp_illegal <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_funct       <= w_funct_nxt;
      r_temp        <= w_temp_nxt;
      r_alu_a       <= w_alu_a_nxt;
      r_alu_b       <= w_alu_b_nxt;
      r_alu_op      <= w_alu_op_nxt;
      r_rsp_valid   <= w_rsp_valid_nxt;
      r_rsp_result  <= w_rsp_result_nxt;
      r_rsp_zero    <= w_rsp_zero_nxt;
      r_rsp_ovf     <= w_rsp_ovf_nxt;
      r_rsp_illegal <= w_rsp_illegal_nxt;
    end
  end

  assign bus.req_ready   = (r_state == StIdle) && !rst;
  assign bus.alu_A       = r_alu_a;
  assign bus.alu_B       = r_alu_b;
  assign bus.alu_op      = r_alu_op;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_result  = r_rsp_result;
  assign bus.rsp_zero    = r_rsp_zero;
  assign bus.rsp_ovf     = r_rsp_ovf;
  assign bus.rsp_illegal = r_rsp_illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: directed vector table, hand-written corner sequences and random requests
// checked against an arithmetic reference model; a behavioural ALU closes the loop.
module tb_alu_issue;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  alu_issue_if #(.DATA_WIDTH(32)) bus ();

  alu_issue #(.DATA_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model of the existing 3-op-bit ALU.
  logic [31:0] alu_r;
  logic        alu_v;
  always_comb begin
    alu_r = '0;
    alu_v = 1'b0;
    case (bus.alu_op)
      3'b000: alu_r = bus.alu_A & bus.alu_B;
      3'b001: alu_r = bus.alu_A | bus.alu_B;
      3'b010: begin
        alu_r = bus.alu_A + bus.alu_B;
        alu_v = (bus.alu_A[31] == bus.alu_B[31]) && (alu_r[31] != bus.alu_A[31]);
      end
      3'b110: begin
        alu_r = bus.alu_A - bus.alu_B;
        alu_v = (bus.alu_A[31] != bus.alu_B[31]) && (alu_r[31] != bus.alu_A[31]);
      end
      3'b111: alu_r = {31'b0, $signed(bus.alu_A) < $signed(bus.alu_B)};
      default: alu_r = '0;
    endcase
  end
  assign bus.alu_result   = alu_r;
  assign bus.alu_overflow = alu_v;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // Reference: what the request means, not how the block computes it.
  function automatic void ref_model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] res, output logic ovf,
                                    output logic ill, output int lat);
    longint sa;
    longint sb;
    longint wide;
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    res  = '0;
    ovf  = 1'b0;
    ill  = 1'b0;
    lat  = 2;
    case (f)
      6'h24: res = a & b;
      6'h25: res = a | b;
      6'h20, 6'h21: begin
        res  = a + b;
        wide = sa + sb;
        ovf  = (f == 6'h20) && (wide > 64'sd2147483647 || wide < -64'sd2147483648);
      end
      6'h22, 6'h23: begin
        res  = a - b;
        wide = sa - sb;
        ovf  = (f == 6'h22) && (wide > 64'sd2147483647 || wide < -64'sd2147483648);
      end
      6'h2A: res = (sa < sb) ? 32'd1 : 32'd0;
      6'h2B: res = (a < b) ? 32'd1 : 32'd0;
      6'h26: begin
        res = a ^ b;
        lat = 3;
      end
      default: begin
        ill = 1'b1;
        lat = 1;
      end
    endcase
  endfunction

  // Called at a negedge; returns just after the accepting posedge.
  task automatic send(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    int n;
    bus.req_valid = 1'b1;
    bus.req_funct = f;
    bus.req_a     = a;
    bus.req_b     = b;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (n >= 20) begin
      n_vec++;
      n_err++;
      $display("FAIL req_ready_timeout: got 0, want 1");
    end
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask

  // Full transaction: lat counts edges after acceptance until rsp_valid is sampled high.
  task automatic run_req(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                         input int bp, output logic [31:0] res, output logic z,
                         output logic ovf, output logic ill, output int lat);
    send(f, a, b);
    lat = 1;
    @(negedge clk);
    while (!bus.rsp_valid && lat < 20) begin
      lat++;
      @(negedge clk);
    end
    repeat (bp) @(negedge clk);
    res = bus.rsp_result;
    z   = bus.rsp_zero;
    ovf = bus.rsp_ovf;
    ill = bus.rsp_illegal;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (!bus.rsp_valid && n < 20) begin
      n++;
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  typedef struct {
    logic [5:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        ovf;
    logic        zero;
    logic        ill;
    int          lat;
  } vec_t;

  vec_t tbl[$];

  logic [5:0] legal_f[9];

  initial begin
    logic [31:0] g_res;
    logic        g_z;
    logic        g_ovf;
    logic        g_ill;
    int          g_lat;
    logic [31:0] e_res;
    logic        e_ovf;
    logic        e_ill;
    int          e_lat;
    logic [5:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] edge_v[6];

    n_vec = 0;
    n_err = 0;
    legal_f = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h2A, 6'h2B};
    edge_v  = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0001};

    tbl.push_back('{6'h20, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b1, 1'b0, 1'b0, 2});
    tbl.push_back('{6'h21, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 2});
    tbl.push_back('{6'h22, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 2});
    tbl.push_back('{6'h22, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0, 2});
    tbl.push_back('{6'h23, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b0, 2});
    tbl.push_back('{6'h2A, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 2});
    tbl.push_back('{6'h2B, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 2});
    tbl.push_back('{6'h26, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 1'b0, 1'b0, 3});
    tbl.push_back('{6'h26, 32'h5A5A_5A5A, 32'h5A5A_5A5A, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 3});
    tbl.push_back('{6'h18, 32'h1111_1111, 32'h2222_2222, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 1});
    tbl.push_back('{6'h24, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'h0F0F_0000, 1'b0, 1'b0, 1'b0, 2});
    tbl.push_back('{6'h25, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 2});
    tbl.push_back('{6'h20, 32'h0000_0002, 32'h0000_0003, 32'h0000_0005, 1'b0, 1'b0, 1'b0, 2});

    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_funct = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", {31'b0, bus.req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    chk("rst_rsp_result", bus.rsp_result, 32'd0);
    chk("rst_rsp_flags", {29'b0, bus.rsp_zero, bus.rsp_ovf, bus.rsp_illegal}, 32'd0);
    chk("rst_alu_A", bus.alu_A, 32'd0);
    chk("rst_alu_B", bus.alu_B, 32'd0);
    chk("rst_alu_op", {29'b0, bus.alu_op}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_req_ready", {31'b0, bus.req_ready}, 32'd1);

    foreach (tbl[i]) begin
      run_req(tbl[i].funct, tbl[i].a, tbl[i].b, 0, g_res, g_z, g_ovf, g_ill, g_lat);
      chk($sformatf("tbl%0d_result", i), g_res, tbl[i].res);
      chk($sformatf("tbl%0d_ovf", i), {31'b0, g_ovf}, {31'b0, tbl[i].ovf});
      chk($sformatf("tbl%0d_zero", i), {31'b0, g_z}, {31'b0, tbl[i].zero});
      chk($sformatf("tbl%0d_illegal", i), {31'b0, g_ill}, {31'b0, tbl[i].ill});
      chk($sformatf("tbl%0d_latency", i), g_lat, tbl[i].lat);
    end

    // SLTU operand MSB flip visible during EX1.
    send(6'h2B, 32'h0000_0001, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("sltu_alu_A", bus.alu_A, 32'h8000_0001);
    chk("sltu_alu_B", bus.alu_B, 32'h7FFF_FFFF);
    chk("sltu_alu_op", {29'b0, bus.alu_op}, 32'd7);
    drain();

    // XOR: AND pass then OR pass on consecutive cycles.
    send(6'h26, 32'hF0F0_F0F0, 32'hFF00_FF00);
    @(negedge clk);
    chk("xor_pass1_op", {29'b0, bus.alu_op}, 32'd0);
    @(negedge clk);
    chk("xor_pass2_op", {29'b0, bus.alu_op}, 32'd1);
    chk("xor_pass2_no_valid", {31'b0, bus.rsp_valid}, 32'd0);
    @(negedge clk);
    chk("xor_valid", {31'b0, bus.rsp_valid}, 32'd1);
    chk("xor_result", bus.rsp_result, 32'h0FF0_0FF0);
    drain();

    // Illegal funct under backpressure with a competing request present.
    send(6'h18, 32'hDEAD_BEEF, 32'h1234_5678);
    @(negedge clk);
    chk("ill_valid", {31'b0, bus.rsp_valid}, 32'd1);
    bus.req_valid = 1'b1;
    bus.req_funct = 6'h20;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("bp%0d_valid", c), {31'b0, bus.rsp_valid}, 32'd1);
      chk($sformatf("bp%0d_req_ready", c), {31'b0, bus.req_ready}, 32'd0);
      chk($sformatf("bp%0d_result", c), bus.rsp_result, 32'd0);
      chk($sformatf("bp%0d_flags", c), {29'b0, bus.rsp_zero, bus.rsp_ovf, bus.rsp_illegal},
          32'b101);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("bp_release_req_ready", {31'b0, bus.req_ready}, 32'd1);
    chk("bp_release_valid", {31'b0, bus.rsp_valid}, 32'd0);

    // Reset during XOR EX2 abandons the operation.
    send(6'h26, 32'hAAAA_5555, 32'h0F0F_F0F0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("ex2_rst_alu_op", {29'b0, bus.alu_op}, 32'd0);
    for (int c = 0; c < 6; c++) begin
      chk($sformatf("ex2_rst_no_valid%0d", c), {31'b0, bus.rsp_valid}, 32'd0);
      @(negedge clk);
    end
    run_req(6'h20, 32'd2, 32'd3, 0, g_res, g_z, g_ovf, g_ill, g_lat);
    chk("after_rst_add_result", g_res, 32'd5);
    chk("after_rst_add_latency", g_lat, 2);

    // Random requests against the reference model, with random response backpressure.
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 9) < 8) f = legal_f[$urandom_range(0, 8)];
      else f = 6'($urandom);
      a = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 5)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 5)] : $urandom;
      ref_model(f, a, b, e_res, e_ovf, e_ill, e_lat);
      run_req(f, a, b, $urandom_range(0, 3), g_res, g_z, g_ovf, g_ill, g_lat);
      chk($sformatf("rnd%0d_f%02h_result", i, f), g_res, e_res);
      chk($sformatf("rnd%0d_f%02h_zero", i, f), {31'b0, g_z}, {31'b0, e_res == 32'd0});
      chk($sformatf("rnd%0d_f%02h_ovf", i, f), {31'b0, g_ovf}, {31'b0, e_ovf});
      chk($sformatf("rnd%0d_f%02h_illegal", i, f), {31'b0, g_ill}, {31'b0, e_ill});
      chk($sformatf("rnd%0d_f%02h_latency", i, f), g_lat, e_lat);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
